// File: rtl/pcie_irq_ctrl_if.sv
// pcie_irq_ctrl_if
//   Groups the PIO register port and the PCIe core interrupt handshake of
//   the interrupt coalescing controller.
//   master : PIO decode / PCIe core side (drives strobes, write data, rdy)
//   slave  : pcie_irq_ctrl (drives read data, read done, interrupt)
//   Signals:
//     reg_wvalid/reg_waddr/reg_wdata : register write strobe, address, data
//     reg_rvalid/reg_raddr           : register read strobe, address
//     reg_rdata/reg_rdone            : read data and its one-cycle valid
//     interrupt/interrupt_rdy        : interrupt request and core acknowledge
interface pcie_irq_ctrl_if;
    logic        reg_wvalid;
    logic [1:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_rvalid;
    logic [1:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic        reg_rdone;
    logic        interrupt;
    logic        interrupt_rdy;

    modport master (
        output reg_wvalid, reg_waddr, reg_wdata, reg_rvalid, reg_raddr, interrupt_rdy,
        input  reg_rdata, reg_rdone, interrupt
    );

    modport slave (
        input  reg_wvalid, reg_waddr, reg_wdata, reg_rvalid, reg_raddr, interrupt_rdy,
        output reg_rdata, reg_rdone, interrupt
    );
endinterface

// File: rtl/pcie_irq_ctrl.sv
// pcie_irq_ctrl
//   Interrupt coalescing controller. Per-FIFO event pulses accumulate in a
//   sticky, clear-on-read status register; masked new events arm a single
//   interrupt request towards the PCIe core, and a programmable holdoff
//   timer spaces successive requests.
//   Ports:
//     clock   : PCIe user clock
//     reset   : asynchronous, active-high
//     irq_in  : NIRQ event pulses (one cycle per event, any number of bits)
//     pending : registered (status & mask) != 0
//     bus     : register port + interrupt handshake (pcie_irq_ctrl_if.slave)
//   Register map: 0 status (read clears, write ignored), 1 mask, 2 holdoff,
//   3 reads as zero.
module pcie_irq_ctrl #(
    parameter int NIRQ          = 16,
    parameter int HW            = 16,
    parameter int HOLDOFF_RESET = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    output logic            pending,
    pcie_irq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state;
    logic [NIRQ-1:0] status;
    logic [NIRQ-1:0] mask;
    logic [HW-1:0]   holdoff;
    logic [HW-1:0]   cnt;
    logic            armed;

    logic status_rd;
    logic arm_evt;
    logic unused_wdata;

    function automatic logic [31:0] zext_irq(input logic [NIRQ-1:0] v);
        logic [31:0] r;
        r = '0;
        r[NIRQ-1:0] = v;
        return r;
    endfunction

    function automatic logic [31:0] zext_cnt(input logic [HW-1:0] v);
        logic [31:0] r;
        r = '0;
        r[HW-1:0] = v;
        return r;
    endfunction

    assign status_rd    = bus.reg_rvalid && (bus.reg_raddr == 2'd0);
    // Only new events arm; bits already sitting in status do not.
    assign arm_evt      = |(irq_in & mask);
    assign unused_wdata = ^bus.reg_wdata;

    // Status accumulation and register writes. A status read reloads status
    // with this cycle's events so nothing coincident with the read is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status  <= '0;
            mask    <= '1;
            holdoff <= HW'(HOLDOFF_RESET);
            pending <= 1'b0;
        end else begin
            if (status_rd) status <= irq_in;
            else           status <= status | irq_in;
            if (bus.reg_wvalid) begin
                case (bus.reg_waddr)
                    2'd1:    mask    <= bus.reg_wdata[NIRQ-1:0];
                    2'd2:    holdoff <= bus.reg_wdata[HW-1:0];
                    default: ;
                endcase
            end
            pending <= |(status & mask);
        end
    end

    // Read port: one-cycle latency, data held until the next read. Values
    // are sampled before any same-cycle write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.reg_rdata <= '0;
            bus.reg_rdone <= 1'b0;
        end else begin
            bus.reg_rdone <= bus.reg_rvalid;
            if (bus.reg_rvalid) begin
                case (bus.reg_raddr)
                    2'd0:    bus.reg_rdata <= zext_irq(status);
                    2'd1:    bus.reg_rdata <= zext_irq(mask);
                    2'd2:    bus.reg_rdata <= zext_cnt(holdoff);
                    default: bus.reg_rdata <= '0;
                endcase
            end
        end
    end

    // Interrupt FSM. Events seen while asserting or holding off leave armed
    // set, which yields exactly one follow-up request once holdoff expires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            armed         <= 1'b0;
            cnt           <= '0;
            bus.interrupt <= 1'b0;
        end else begin
            // A new event in the same cycle as the IDLE->ASSERT hand-off wins.
            if (arm_evt)                        armed <= 1'b1;
            else if (state == IDLE && armed)    armed <= 1'b0;

            case (state)
                IDLE: begin
                    if (armed) begin
                        state         <= ASSERT;
                        bus.interrupt <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (bus.interrupt_rdy) begin
                        state         <= HOLDOFF;
                        bus.interrupt <= 1'b0;
                        cnt           <= holdoff;
                    end
                end
                HOLDOFF: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_irq_ctrl.sv
// tb_pcie_irq_ctrl
//   Directed bench for pcie_irq_ctrl. Register read expectations go into a
//   queue when the read strobe is driven and are compared when reg_rdone
//   pulses; interrupt timing is checked inline by the stimulus sequence.
module tb_pcie_irq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] irq_in;
    logic        pending;

    pcie_irq_ctrl_if bus();

    pcie_irq_ctrl #(
        .NIRQ(16),
        .HW(16),
        .HOLDOFF_RESET(256)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .irq_in  (irq_in),
        .pending (pending),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.reg_wvalid = 1'b1;
        bus.reg_waddr  = addr;
        bus.reg_wdata  = data;
        tick(1);
        bus.reg_wvalid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] addr, input logic [31:0] expv);
        bus.reg_rvalid = 1'b1;
        bus.reg_raddr  = addr;
        exp_q.push_back(expv);
        tick(1);
        bus.reg_rvalid = 1'b0;
    endtask

    // Read scoreboard
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.reg_rdone === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rd_extra: observed rdone with rdata=0x%0h expected no read", bus.reg_rdata);
            end
            if (exp_q.size() != 0) check("rd_data", bus.reg_rdata, exp_q.pop_front());
        end
    end

    initial begin
        int high;
        int rises;
        int first;
        int r[$];
        logic prev;

        reset             = 1'b1;
        irq_in            = '0;
        bus.reg_wvalid    = 1'b0;
        bus.reg_waddr     = '0;
        bus.reg_wdata     = '0;
        bus.reg_rvalid    = 1'b0;
        bus.reg_raddr     = '0;
        bus.interrupt_rdy = 1'b0;
        tick(2);
        check("rst_interrupt", 32'(bus.interrupt), 0);
        check("rst_rdone",     32'(bus.reg_rdone), 0);
        check("rst_rdata",     bus.reg_rdata, 0);
        check("rst_pending",   32'(pending), 0);
        reset = 1'b0;
        tick(1);
        rd(2'd1, 32'h0000_FFFF);
        rd(2'd2, 32'd256);
        rd(2'd0, 32'h0);
        tick(2);

        // Single event, rdy tied high
        bus.interrupt_rdy = 1'b1;
        irq_in = 16'h0001;
        tick(1);
        irq_in = '0;
        check("t1_int_n1", 32'(bus.interrupt), 0);
        tick(1);
        check("t1_int_n2", 32'(bus.interrupt), 1);
        tick(1);
        check("t1_int_n3", 32'(bus.interrupt), 0);
        high = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.interrupt) high++;
        end
        check("t1_no_more", high, 0);
        rd(2'd0, 32'h0001);
        rd(2'd0, 32'h0000);
        tick(280);

        // Masked event
        wr(2'd1, 32'h0);
        irq_in = 16'h8000;
        tick(1);
        irq_in = '0;
        high = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.interrupt) high++;
        end
        check("t2_no_int", high, 0);
        check("t2_pending", 32'(pending), 0);
        rd(2'd0, 32'h8000);
        wr(2'd1, 32'hFFFF);
        tick(2);

        // Rate limiting: holdoff 10, continuous events
        wr(2'd2, 32'd10);
        rd(2'd2, 32'd10);
        prev = 1'b0;
        high = 0;
        r.delete();
        for (int i = 0; i < 100; i++) begin
            irq_in = 16'h0001;
            tick(1);
            if (bus.interrupt) high++;
            if (bus.interrupt && !prev) r.push_back(i);
            prev = bus.interrupt;
        end
        irq_in = '0;
        check("t3_pulses", r.size(), 8);
        check("t3_high_cycles", high, 8);
        for (int k = 1; k < r.size(); k++) check("t3_spacing", r[k] - r[k-1], 13);
        tick(30);

        // Status read coincident with a new event
        rd(2'd0, 32'h0001);
        tick(1);
        irq_in = 16'h0002;
        tick(1);
        irq_in = '0;
        tick(1);
        check("t4_pending", 32'(pending), 1);
        irq_in = 16'h0004;
        bus.reg_rvalid = 1'b1;
        bus.reg_raddr  = 2'd0;
        exp_q.push_back(32'h0002);
        tick(1);
        irq_in = '0;
        exp_q.push_back(32'h0004);
        tick(1);
        bus.reg_rvalid = 1'b0;
        tick(30);

        // Several events while asserted give exactly one follow-up
        bus.interrupt_rdy = 1'b0;
        irq_in = 16'h0001;
        tick(1);
        irq_in = '0;
        tick(1);
        check("t5_int_on", 32'(bus.interrupt), 1);
        for (int i = 0; i < 3; i++) begin
            irq_in = 16'h0010;
            tick(1);
            irq_in = '0;
            tick(1);
        end
        check("t5_int_held", 32'(bus.interrupt), 1);
        bus.interrupt_rdy = 1'b1;
        prev  = 1'b1;
        rises = 0;
        first = -1;
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            if (bus.interrupt && !prev) begin
                rises++;
                if (first < 0) first = j;
            end
            prev = bus.interrupt;
        end
        check("t5_first_rise", first, 13);
        check("t5_rises", rises, 1);
        tick(20);

        // Holdoff rewrite during a count affects only the next load
        wr(2'd2, 32'd200);
        prev = 1'b0;
        r.delete();
        for (int j = 0; j < 260; j++) begin
            irq_in = 16'h0001;
            if (j == 20) begin
                bus.reg_wvalid = 1'b1;
                bus.reg_waddr  = 2'd2;
                bus.reg_wdata  = 32'd0;
            end
            if (j == 21) bus.reg_wvalid = 1'b0;
            tick(1);
            if (bus.interrupt && !prev) r.push_back(j);
            prev = bus.interrupt;
        end
        irq_in = '0;
        check("t6_rises_min", 32'(r.size() >= 3), 1);
        if (r.size() >= 3) begin
            check("t6_long_gap", r[1] - r[0], 203);
            check("t6_short_gap", r[2] - r[1], 3);
        end
        tick(10);

        // Stuck request, then asynchronous reset
        wr(2'd1, 32'h00FF);
        rd(2'd1, 32'h00FF);
        bus.interrupt_rdy = 1'b0;
        irq_in = 16'h0001;
        tick(1);
        irq_in = '0;
        tick(1);
        check("t7_int_on", 32'(bus.interrupt), 1);
        high = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (bus.interrupt) high++;
        end
        check("t7_int_50", high, 50);
        check("t7_pending_pre", 32'(pending), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t7_rst_interrupt", 32'(bus.interrupt), 0);
        check("t7_rst_rdata",     bus.reg_rdata, 0);
        check("t7_rst_rdone",     32'(bus.reg_rdone), 0);
        check("t7_rst_pending",   32'(pending), 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        rd(2'd1, 32'h0000_FFFF);
        rd(2'd2, 32'd256);
        rd(2'd0, 32'h0);
        rd(2'd3, 32'h0);
        tick(3);
        check("t7_no_int", 32'(bus.interrupt), 0);
        check("rd_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
